recirculador_param: RTL and testbench
=====================================

RECIRCULADOR_PARAM -- requirements
Module: recirculador_param

Interface
REQ-001 Parameter DATA_W, default 8: bits per channel word.
REQ-002 Parameter NCH, default 4, legal 1..16: number of input channels.
REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  reset, asynchronous and active-low.
REQ-006 data_in  input  NCH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 valid_in  input  NCH  per-channel word-valid qualifier.
REQ-008 selector_IDLE  input  1  requested mode: 1 = recirculate, 0 = forward.
REQ-009 fwd_full  input  NCH  per-channel downstream-full flag on the forward path.
REQ-010 data_fwd / valid_fwd  output  NCH*DATA_W / NCH  forward path, registered.
REQ-011 data_rec / valid_rec  output  NCH*DATA_W / NCH  recirculation path, registered.
REQ-012 mode_state  output  2  current FSM state encoding.
REQ-013 fwd_cnt / rec_cnt / div_cnt  output  CNT_W each  forwarded, recirculated and diverted word totals.

Function
REQ-014 FSM states SHALL be REC=0, TO_FWD=1, FWD=2, TO_REC=3.
REQ-015 Mode switches SHALL occur only on a quiet cycle, meaning valid_in == 0, so a burst is never split across paths.
REQ-016 In REC, if selector_IDLE=0, the FSM SHALL go to FWD when the cycle is quiet, otherwise to TO_FWD.
REQ-017 In TO_FWD, the FSM SHALL go to FWD on a quiet cycle, and back to REC if selector_IDLE returns to 1 first.
REQ-018 FWD, TO_REC and the return to REC SHALL mirror REQ-016 and REQ-017 with the polarity inverted.
REQ-019 Routing SHALL use the old mode: REC and TO_FWD route as recirculate; FWD and TO_REC route as forward.
REQ-020 A word valid on channel i in a recirculate-routed cycle SHALL appear on data_rec[i] with valid_rec[i]=1 exactly 1 cycle later.
REQ-021 A word valid on channel i in a forward-routed cycle SHALL appear on data_fwd[i] with valid_fwd[i]=1 exactly 1 cycle later, unless fwd_full[i]=1.
REQ-022 A forward-routed word with fwd_full[i]=1 SHALL be diverted to data_rec[i] and valid_rec[i] 1 cycle later; it counts in rec_cnt and in div_cnt.
REQ-023 For each channel, at most one of valid_fwd[i] and valid_rec[i] SHALL be high in a cycle; both SHALL be low when valid_in[i] was low.
REQ-024 A data output whose valid is low SHALL hold its last value and never show X.
REQ-025 Each counter SHALL add the popcount of words sent to its path in that cycle, 0..NCH per cycle.
REQ-026 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 fwd_cnt SHALL count words reaching data_fwd only; diverted words SHALL be excluded from it.
REQ-028 Channels SHALL be fully independent; there is no cross-channel reordering.
REQ-029 Throughput SHALL be NCH words per cycle, with no stalls.

Reset
REQ-030 While reset_L=0, mode_state SHALL be REC, all valids 0, all data outputs 0 and all counters 0, asynchronously.
REQ-031 Reset asserted mid-burst SHALL drop words in flight; the first edge after release samples inputs normally in REC.
REQ-032 Deasserting reset_L SHALL be synchronised by the integration; this block does not synchronise it.

Verification
REQ-033 Reset, then valid_in=4'b1111 with data 0x11,0x22,0x33,0x44 and selector_IDLE=1 -> next cycle valid_rec=4'b1111 with the same data; rec_cnt=4.
REQ-034 Drop selector_IDLE to 0 during a 3-cycle burst -> mode_state=TO_FWD; all 3 words appear on rec; FWD is reached on the first quiet cycle.
REQ-035 In FWD, channel 2 valid with fwd_full=4'b0100, data 0xA5 -> valid_rec=4'b0100 carrying 0xA5; div_cnt and rec_cnt each increment by 1; fwd_cnt is unchanged.
REQ-036 In TO_FWD, selector_IDLE returns to 1 before a quiet cycle -> mode_state=REC; no word appears on fwd.
REQ-037 With CNT_W=4, send 20 forwarded words -> fwd_cnt holds 15.
REQ-038 Pulse reset_L low for 1 ns mid-burst while in FWD -> outputs clear immediately and mode_state=REC; no X appears.

Source files
------------

// File: rtl/recirculador_param_if.sv
// Channel bundle for the recirculator: input words, both output paths,
// mode and the three word counters.
`timescale 1ns/1ps
interface recirculador_param_if #(
   parameter int DATA_W = 8,
   parameter int NCH    = 4,
   parameter int CNT_W  = 16
);
   logic [NCH*DATA_W-1:0] data_in;
   logic [NCH-1:0]        valid_in;
   logic                  selector_IDLE;
   logic [NCH-1:0]        fwd_full;
   logic [NCH*DATA_W-1:0] data_fwd;
   logic [NCH-1:0]        valid_fwd;
   logic [NCH*DATA_W-1:0] data_rec;
   logic [NCH-1:0]        valid_rec;
   logic [1:0]            mode_state;
   logic [CNT_W-1:0]      fwd_cnt;
   logic [CNT_W-1:0]      rec_cnt;
   logic [CNT_W-1:0]      div_cnt;

   modport master (
      output data_in, valid_in, selector_IDLE, fwd_full,
      input  data_fwd, valid_fwd, data_rec, valid_rec,
      input  mode_state, fwd_cnt, rec_cnt, div_cnt
   );

   modport slave (
      input  data_in, valid_in, selector_IDLE, fwd_full,
      output data_fwd, valid_fwd, data_rec, valid_rec,
      output mode_state, fwd_cnt, rec_cnt, div_cnt
   );
endinterface

// File: rtl/recirculador_param.sv
// Multi-channel recirculate/forward router; mode changes only on quiet
// cycles, full forward lanes divert to the recirculation path.
`timescale 1ns/1ps
module recirculador_param #(
   parameter int DATA_W = 8,
   parameter int NCH    = 4,
   parameter int CNT_W  = 16
) (
   input  logic clk,
   input  logic reset_L,
   recirculador_param_if.slave bus
);
   localparam int PW = $clog2(NCH + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

   typedef enum logic [1:0] {
      REC    = 2'd0,
      TO_FWD = 2'd1,
      FWD    = 2'd2,
      TO_REC = 2'd3
   } mode_t;

   mode_t state, stateNxt;
   logic quiet, recMode;
   logic [NCH-1:0] fwdHit, recHit, divHit;

   function automatic logic [PW-1:0] popCnt(input logic [NCH-1:0] v);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < NCH; i++) c = c + PW'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] satAdd(
      input logic [CNT_W-1:0] a,
      input logic [PW-1:0]    b
   );
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s > SW'({CNT_W{1'b1}})) return '1;
      return s[CNT_W-1:0];
   endfunction

   assign quiet = ~|bus.valid_in;

   always_comb begin
      stateNxt = state;
      unique case (state)
         REC:    if (!bus.selector_IDLE) stateNxt = quiet ? FWD : TO_FWD;
         TO_FWD: if (bus.selector_IDLE)  stateNxt = REC;
                 else if (quiet)         stateNxt = FWD;
         FWD:    if (bus.selector_IDLE)  stateNxt = quiet ? REC : TO_REC;
         TO_REC: if (!bus.selector_IDLE) stateNxt = FWD;
                 else if (quiet)         stateNxt = REC;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= REC;
      else          state <= stateNxt;
   end

   // Routing follows the mode held before this edge, not stateNxt.
   assign recMode = (state == REC) || (state == TO_FWD);
   assign divHit  = recMode ? '0 : (bus.valid_in & bus.fwd_full);
   assign fwdHit  = recMode ? '0 : (bus.valid_in & ~bus.fwd_full);
   assign recHit  = recMode ? bus.valid_in : divHit;

   assign bus.mode_state = state;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         bus.valid_fwd <= '0;
         bus.valid_rec <= '0;
         bus.data_fwd  <= '0;
         bus.data_rec  <= '0;
      end else begin
         bus.valid_fwd <= fwdHit;
         bus.valid_rec <= recHit;
         for (int i = 0; i < NCH; i++) begin
            if (fwdHit[i])
               bus.data_fwd[i*DATA_W +: DATA_W] <= bus.data_in[i*DATA_W +: DATA_W];
            if (recHit[i])
               bus.data_rec[i*DATA_W +: DATA_W] <= bus.data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         bus.fwd_cnt <= '0;
         bus.rec_cnt <= '0;
         bus.div_cnt <= '0;
      end else begin
         bus.fwd_cnt <= satAdd(bus.fwd_cnt, popCnt(fwdHit));
         bus.rec_cnt <= satAdd(bus.rec_cnt, popCnt(recHit));
         bus.div_cnt <= satAdd(bus.div_cnt, popCnt(divHit));
      end
   end
endmodule

// File: tb/tb_recirculador_param.sv
// Scoreboard bench for recirculador_param: a wide-counter and a
// 4-bit-counter instance see identical stimulus.
`timescale 1ns/1ps
module tb_recirculador_param;
   localparam int DW = 8;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   always #5 clk = ~clk;

   recirculador_param_if #(.DATA_W(DW), .NCH(N), .CNT_W(16)) bIf ();
   recirculador_param_if #(.DATA_W(DW), .NCH(N), .CNT_W(4))  sIf ();

   assign sIf.data_in       = bIf.data_in;
   assign sIf.valid_in      = bIf.valid_in;
   assign sIf.selector_IDLE = bIf.selector_IDLE;
   assign sIf.fwd_full      = bIf.fwd_full;

   recirculador_param #(.DATA_W(DW), .NCH(N), .CNT_W(16)) dut (
      .clk(clk), .reset_L(reset_L), .bus(bIf.slave)
   );
   recirculador_param #(.DATA_W(DW), .NCH(N), .CNT_W(4)) dutS (
      .clk(clk), .reset_L(reset_L), .bus(sIf.slave)
   );

   typedef struct {
      logic [3:0]  vf, vr;
      logic [31:0] df, dr;
      logic [1:0]  st;
      int          fc, rc, dc;
   } exp_t;

   exp_t sb[$];
   int nVec = 0;
   int nMis = 0;

   int mState, mFc, mRc, mDc;
   logic [31:0] mDf, mDr;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   // REC and TO_FWD share transitions, as do FWD and TO_REC.
   function automatic int nextSt(input int s, input bit sel, input bit q);
      if (s < 2) return sel ? 0 : (q ? 2 : 1);
      return !sel ? 2 : (q ? 0 : 3);
   endfunction

   task automatic modelReset();
      mState = 0;
      mFc = 0; mRc = 0; mDc = 0;
      mDf = '0; mDr = '0;
   endtask

   task automatic predict();
      exp_t e;
      bit recM;
      recM = (mState == 0) || (mState == 1);
      e.vf = '0;
      e.vr = '0;
      for (int i = 0; i < N; i++) begin
         if (bIf.valid_in[i]) begin
            if (recM || bIf.fwd_full[i]) begin
               e.vr[i] = 1'b1;
               mDr[i*DW +: DW] = bIf.data_in[i*DW +: DW];
               mRc++;
               if (!recM) mDc++;
            end else begin
               e.vf[i] = 1'b1;
               mDf[i*DW +: DW] = bIf.data_in[i*DW +: DW];
               mFc++;
            end
         end
      end
      mState = nextSt(mState, bIf.selector_IDLE, bIf.valid_in == '0);
      e.df = mDf; e.dr = mDr;
      e.st = 2'(mState);
      e.fc = mFc; e.rc = mRc; e.dc = mDc;
      sb.push_back(e);
   endtask

   task automatic setIn(input logic [3:0] v, input logic [31:0] d,
                        input bit sel, input logic [3:0] full);
      bIf.valid_in      = v;
      bIf.data_in       = d;
      bIf.selector_IDLE = sel;
      bIf.fwd_full      = full;
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d,
                        input bit sel, input logic [3:0] full);
      @(negedge clk);
      setIn(v, d, sel, full);
      predict();
   endtask

   task automatic checkReset(input string tag);
      chk({tag, "_st"},  64'(bIf.mode_state), 64'd0);
      chk({tag, "_vf"},  64'(bIf.valid_fwd), 64'd0);
      chk({tag, "_vr"},  64'(bIf.valid_rec), 64'd0);
      chk({tag, "_df"},  64'(bIf.data_fwd), 64'd0);
      chk({tag, "_dr"},  64'(bIf.data_rec), 64'd0);
      chk({tag, "_cnt"}, {16'd0, bIf.fwd_cnt, bIf.rec_cnt, bIf.div_cnt}, 64'd0);
      chk({tag, "_sc"},  {52'd0, sIf.fwd_cnt, sIf.rec_cnt, sIf.div_cnt}, 64'd0);
   endtask

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("validFwd", 64'(bIf.valid_fwd), 64'(e.vf));
         chk("validRec", 64'(bIf.valid_rec), 64'(e.vr));
         chk("dataFwd",  64'(bIf.data_fwd),  64'(e.df));
         chk("dataRec",  64'(bIf.data_rec),  64'(e.dr));
         chk("mode",     64'(bIf.mode_state), 64'(e.st));
         chk("fwdCnt",   64'(bIf.fwd_cnt), 64'(e.fc));
         chk("recCnt",   64'(bIf.rec_cnt), 64'(e.rc));
         chk("divCnt",   64'(bIf.div_cnt), 64'(e.dc));
         chk("sFwdCnt",  64'(sIf.fwd_cnt), 64'(sat15(e.fc)));
         chk("sRecCnt",  64'(sIf.rec_cnt), 64'(sat15(e.rc)));
         chk("sDivCnt",  64'(sIf.div_cnt), 64'(sat15(e.dc)));
      end
   end

   initial begin
      bit sel;
      modelReset();
      setIn(4'h0, 32'h0, 1'b1, 4'h0);
      #12;
      checkReset("rst");
      @(negedge clk);
      reset_L = 1'b1;

      drive(4'hF, 32'h44332211, 1'b1, 4'h0);
      drive(4'h0, 32'h0, 1'b1, 4'h0);

      repeat (3) drive(4'hF, $urandom, 1'b0, 4'h0);
      drive(4'h0, 32'h0, 1'b0, 4'h0);

      drive(4'b0100, 32'h00A50000, 1'b0, 4'b0100);
      drive(4'hF, $urandom, 1'b0, 4'b1010);
      drive(4'b0101, $urandom, 1'b0, 4'b0001);

      drive(4'h0, 32'h0, 1'b1, 4'h0);
      drive(4'b0011, $urandom, 1'b0, 4'h0);
      drive(4'b0001, $urandom, 1'b1, 4'h0);
      drive(4'h0, 32'h0, 1'b1, 4'h0);

      drive(4'h0, 32'h0, 1'b0, 4'h0);
      repeat (5) drive(4'hF, $urandom, 1'b0, 4'h0);
      @(posedge clk);
      #2;
      chk("sat15", 64'(sIf.fwd_cnt), 64'd15);

      sel = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 4) == 0) sel = ~sel;
         drive(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
               $urandom, sel, 4'($urandom));
      end

      drive(4'h0, 32'h0, 1'b0, 4'h0);
      drive(4'hF, $urandom, 1'b0, 4'h0);
      @(negedge clk);
      setIn(4'hF, $urandom, 1'b0, 4'h0);
      predict();
      #2;
      reset_L = 1'b0;
      #0.5;
      checkReset("midRst");
      #0.5;
      reset_L = 1'b1;
      sb.delete();
      modelReset();
      predict();
      drive(4'b0110, $urandom, 1'b0, 4'b0010);
      drive(4'h0, 32'h0, 1'b0, 4'h0);
      drive(4'b1001, $urandom, 1'b0, 4'b1000);

      @(posedge clk);
      #3;
      chk("drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule
